// File: rtl/uart_tx_hex_feed.sv
// Formats one X/Y/Z sample as an ASCII hex line and streams it byte by byte into the UART TX FIFO.
// Optional `UART_TX_HEX_FEED_SEQNUM_EN adds a 2-digit hex sequence-number prefix "nn " to every line.
module uart_tx_hex_feed #(
    parameter int LINE_TERM_CRLF = 1
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rst_20mhz,
    input  logic [15:0] i_dat_x,
    input  logic [15:0] i_dat_y,
    input  logic [15:0] i_dat_z,
    input  logic        i_dat_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_drop
);

`ifdef UART_TX_HEX_FEED_SEQNUM_EN
    localparam int PFX   = 3;
    localparam int IDX_W = 6;
`else
    localparam int PFX   = 0;
    localparam int IDX_W = 5;
`endif
    localparam int LINE_LEN = PFX + ((LINE_TERM_CRLF != 0) ? 22 : 21);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_x;
    logic [15:0]      r_y;
    logic [15:0]      r_z;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_drop;
    logic [7:0]       w_char;
`ifdef UART_TX_HEX_FEED_SEQNUM_EN
    logic [7:0]       r_seq_cnt;
    logic [7:0]       r_seq_hold;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        return v[(3 - k) * 4 +: 4];
    endfunction

    // p is the position within "X:hhhh Y:hhhh Z:hhhh" + terminator, prefix already removed
    function automatic logic [7:0] body_char(input int p, input logic [15:0] x,
                                             input logic [15:0] y, input logic [15:0] z);
        logic [7:0] c;
        c = 8'h00;
        if (p == 0)                  c = 8'h58;
        else if (p == 7)             c = 8'h59;
        else if (p == 14)            c = 8'h5A;
        else if (p == 1 || p == 8 || p == 15) c = 8'h3A;
        else if (p == 6 || p == 13)  c = 8'h20;
        else if (p >= 2 && p <= 5)   c = hex_char(nib(x, p - 2));
        else if (p >= 9 && p <= 12)  c = hex_char(nib(y, p - 9));
        else if (p >= 16 && p <= 19) c = hex_char(nib(z, p - 16));
        else if (p == 20)            c = (LINE_TERM_CRLF != 0) ? 8'h0D : 8'h0A;
        else if (p == 21)            c = 8'h0A;
        return c;
    endfunction

    always_comb begin
        w_char = body_char(int'(r_idx) - PFX, r_x, r_y, r_z);
`ifdef UART_TX_HEX_FEED_SEQNUM_EN
        if (r_idx == IDX_W'(0))      w_char = hex_char(r_seq_hold[7:4]);
        else if (r_idx == IDX_W'(1)) w_char = hex_char(r_seq_hold[3:0]);
        else if (r_idx == IDX_W'(2)) w_char = 8'h20;
`endif
    end

    // o_tx_valid follows a sampled i_tx_ready by one cycle; the FIFO's almost-full margin covers the lag
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
`ifdef UART_TX_HEX_FEED_SEQNUM_EN
            r_seq_cnt  <= 8'h00;
            r_seq_hold <= 8'h00;
`endif
        end else begin
            r_tx_valid <= 1'b0;
            r_drop     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_dat_valid) begin
                        r_x     <= i_dat_x;
                        r_y     <= i_dat_y;
                        r_z     <= i_dat_z;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_EMIT;
`ifdef UART_TX_HEX_FEED_SEQNUM_EN
                        r_seq_hold <= r_seq_cnt;
                        r_seq_cnt  <= r_seq_cnt + 8'd1;
`endif
                    end
                end
                ST_EMIT: begin
                    if (i_dat_valid) r_drop <= 1'b1;
                    if (i_tx_ready) begin
                        r_tx_data  <= w_char;
                        r_tx_valid <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_drop     = r_drop;

endmodule
